// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - digit scan multiplexer feeding one shared decoder_7seg
// Define SCAN_BLANK_EN to insert a BLANK_CYCLES all-off gap after every digit.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [1:0]            wr_data,
  output logic [1:0]            code_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [IDX_W-1:0]      active_idx,
  output logic                  frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]   ADDR_LIM   = (IDX_W + 1)'(NUM_DIGITS);

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             step;
  logic             wrap;
  logic [1:0]       store [NUM_DIGITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = active_idx;
    step    = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          cnt_d = '0;
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
`else
          step = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
          step    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // An index step still completes on the edge enable drops, so a wrap is never lost.
    if (step) begin
      if (active_idx == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = active_idx + 1'b1;
      end
    end
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      active_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_idx <= idx_d;
      frame_done <= wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) store[i] <= 2'b00;
      code_out <= 2'b00;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < ADDR_LIM)) store[wr_addr] <= wr_data;
      code_out <= store[active_idx];
    end
  end

  assign digit_en = (state_q == DRIVE) ? (NUM_DIGITS'(1) << active_idx) : '0;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - directed bench for seg7_scan_controller (4-digit and 6-digit builds)
// Honours SCAN_BLANK_EN when defined for the whole compile.
module tb_seg7_scan_controller;

`ifdef SCAN_BLANK_EN
  localparam int BL   = 2;
  localparam int BL6  = 1;
  localparam int PRE6 = 6;
`else
  localparam int BL   = 0;
  localparam int BL6  = 0;
  localparam int PRE6 = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, wr_en;
  logic [1:0] wr_addr, wr_data;
  logic [1:0] code_out;
  logic [3:0] digit_en;
  logic [1:0] active_idx;
  logic       frame_done;

  logic       enable6, wr_en6;
  logic [2:0] wr_addr6;
  logic [1:0] wr_data6;
  logic [1:0] code_out6;
  logic [5:0] digit_en6;
  logic [2:0] active_idx6;
  logic       frame_done6;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_code;
  logic [1:0] exp6 [6];

  always #5 clk = ~clk;

  seg7_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .code_out(code_out), .digit_en(digit_en),
    .active_idx(active_idx), .frame_done(frame_done)
  );

  seg7_scan_controller #(.NUM_DIGITS(6), .REFRESH_DIV(2), .BLANK_CYCLES(1)) u_dut6 (
    .clk(clk), .reset(reset), .enable(enable6), .wr_en(wr_en6), .wr_addr(wr_addr6),
    .wr_data(wr_data6), .code_out(code_out6), .digit_en(digit_en6),
    .active_idx(active_idx6), .frame_done(frame_done6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 2'b11;
    enable6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = 3'd0; wr_data6 = 2'b00;
    tick(); tick();
    check("rst_code", 32'(code_out), 0);
    check("rst_en", 32'(digit_en), 0);
    check("rst_idx", 32'(active_idx), 0);
    check("rst_frame", 32'(frame_done), 0);
    reset = 1'b0; enable = 1'b0; wr_en = 1'b0;
    tick();
    check("rst_store0", 32'(code_out), 0);

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 2'(i);
      tick();
    end
    wr_en = 1'b0;
    check("idle_en", 32'(digit_en), 0);

    enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          exp_code = (c != 0) ? d : ((f == 0 && d == 0) ? 0 : (d + 3) % 4);
          check("scan_en", 32'(digit_en), 32'(1) << d);
          check("scan_idx", 32'(active_idx), 32'(d));
          check("scan_code", 32'(code_out), 32'(exp_code));
          check("scan_frame", 32'(frame_done), (f > 0 && d == 0 && c == 0) ? 1 : 0);
        end
        for (int b = 0; b < BL; b++) begin
          tick();
          check("blank_en", 32'(digit_en), 0);
          check("blank_idx", 32'(active_idx), 32'(d));
          check("blank_code", 32'(code_out), 32'(d));
          check("blank_frame", 32'(frame_done), 0);
        end
      end
    end

    for (int i = 0; i < 10 + 2 * BL; i++) tick();
    check("pre_off_idx", 32'(active_idx), 2);
    check("pre_off_en", 32'(digit_en), 4);
    check("pre_off_code", 32'(code_out), 2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("off_en", 32'(digit_en), 0);
      check("off_idx", 32'(active_idx), 2);
      check("off_frame", 32'(frame_done), 0);
    end
    enable = 1'b1;
    tick();
    check("resume_en0", 32'(digit_en), 4);
    check("resume_idx", 32'(active_idx), 2);
    tick();
    check("resume_en1", 32'(digit_en), 4);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 2'b11;
    tick();
    wr_en = 1'b0;
    check("wr_old_code", 32'(code_out), 2);
    check("resume_en2", 32'(digit_en), 4);
    tick();
    check("wr_new_code", 32'(code_out), 3);
    check("resume_en3", 32'(digit_en), 4);
    tick();
    check("after_slot_en", 32'(digit_en), (BL != 0) ? 0 : 8);
    check("after_slot_idx", 32'(active_idx), (BL != 0) ? 2 : 3);
    check("after_slot_code", 32'(code_out), 3);

    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 2'b10;
    for (int i = 0; i < PRE6; i++) begin
      tick();
      wr_en = 1'b0;
    end
    check("mid_idx", 32'(active_idx), 3);
    check("mid_en", 32'(digit_en), (BL != 0) ? 0 : 8);
    reset = 1'b1;
    tick();
    check("midrst_idx", 32'(active_idx), 0);
    check("midrst_en", 32'(digit_en), 0);
    check("midrst_frame", 32'(frame_done), 0);
    check("midrst_code", 32'(code_out), 0);
    reset = 1'b0; enable = 1'b0;
    tick();
    check("midrst_store0", 32'(code_out), 0);
    check("midrst_idle_en", 32'(digit_en), 0);

    for (int i = 0; i < 8; i++) begin
      wr_en6 = 1'b1; wr_addr6 = 3'(i);
      wr_data6 = (i < 6) ? 2'(3 - (i % 4)) : 2'b01;
      if (i < 6) exp6[i] = 2'(3 - (i % 4));
      tick();
    end
    wr_en6 = 1'b0; enable6 = 1'b1;
    tick(); tick();
    check("d6_code0", 32'(code_out6), 32'(exp6[0]));
    check("d6_idx0", 32'(active_idx6), 0);
    for (int d = 1; d < 6; d++) begin
      for (int i = 0; i < 2 + BL6; i++) tick();
      check("d6_code", 32'(code_out6), 32'(exp6[d]));
      check("d6_idx", 32'(active_idx6), 32'(d));
      check("d6_en", 32'(digit_en6), 32'(1) << d);
    end
    for (int i = 0; i < 1 + BL6; i++) tick();
    check("d6_wrap_idx", 32'(active_idx6), 0);
    check("d6_wrap_frame", 32'(frame_done6), 1);
    check("d6_wrap_en", 32'(digit_en6), 1);
    enable6 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
